// File: rtl/control_unit.sv
// control_unit: hardwired Mini SRC control sequencer (fetch, decode, T-state stepping).
// Define MUL_DIV_EN to compile in the mul/div sequence; otherwise those opcodes run as nop.
module control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR_Data,
  input  logic        CON_out,
  output logic        PC_in,
  output logic        IR_in,
  output logic        Y_in,
  output logic        Z_in,
  output logic        HI_in,
  output logic        LO_in,
  output logic        MAR_in,
  output logic        MDR_in,
  output logic        OutPort_in,
  output logic        CON_in,
  output logic        Rin,
  output logic        PC_out,
  output logic        Zhigh_out,
  output logic        Zlow_out,
  output logic        HI_out,
  output logic        LO_out,
  output logic        MDR_out,
  output logic        InPort_out,
  output logic        C_out,
  output logic        Rout,
  output logic        BAout,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic [4:0]  alu_instruction_bits,
  output logic        Run
);
  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
  typedef enum logic [3:0] {
    C_NOP, C_HALT, C_REG, C_IMM, C_UN, C_MD, C_LD, C_LDI, C_ST,
    C_BR, C_JR, C_IN, C_OUT, C_MFHI, C_MFLO
  } cls_t;
  state_t state, next, last;
  cls_t cls;
  logic [4:0] op, alu_code;
  logic unused_ir;
  assign op = IR_Data[31:27];
  assign unused_ir = ^IR_Data[26:0];
  always_comb begin
    cls = C_NOP;
    if (op >= 5'd3 && op <= 5'd11) cls = C_REG;
    else
      case (op)
        5'd0:  cls = C_LD;
        5'd1:  cls = C_LDI;
        5'd2:  cls = C_ST;
        5'd12, 5'd13, 5'd14: cls = C_IMM;
`ifdef MUL_DIV_EN
        5'd15, 5'd16: cls = C_MD;
`endif
        5'd17, 5'd18: cls = C_UN;
        5'd19: cls = C_BR;
        5'd20: cls = C_JR;
        5'd22: cls = C_IN;
        5'd23: cls = C_OUT;
        5'd24: cls = C_MFHI;
        5'd25: cls = C_MFLO;
        5'd27: cls = C_HALT;
        default: cls = C_NOP;
      endcase
  end
  // Final T-state of each class; nop and halt both end fetch at T2.
  always_comb begin
    case (cls)
      C_JR, C_IN, C_OUT, C_MFHI, C_MFLO: last = T3;
      C_UN:                              last = T4;
      C_REG, C_IMM, C_LDI:               last = T5;
      C_MD, C_BR:                        last = T6;
      C_LD, C_ST:                        last = T7;
      default:                           last = T2;
    endcase
  end
  always_comb
    alu_code = (cls == C_REG || cls == C_UN || cls == C_MD) ? op :
               (op == 5'd13) ? 5'd5 :
               (op == 5'd14) ? 5'd6 : 5'd3;
  always_comb
    next = (state == HALT) ? HALT :
           (state == T2 && cls == C_HALT) ? HALT :
           (state == last) ? T0 : state_t'(state + 4'd1);
  always_ff @(posedge clk or posedge clr)
    if (clr) state <= IDLE;
    else state <= next;
  always_comb begin
    {PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, CON_in, Rin} = '0;
    {PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out, Rout, BAout} = '0;
    {IncPC, Read, Write, Gra, Grb, Grc} = '0;
    alu_instruction_bits = '0;
    Run = (state != HALT);
    case (state)
      T0: {PC_out, MAR_in, IncPC, Z_in} = '1;
      T1: {Zlow_out, PC_in, Read, MDR_in} = '1;
      T2: {MDR_out, IR_in} = '1;
      T3:
        case (cls)
          C_REG, C_IMM: {Grb, Rout, Y_in} = '1;
          C_UN: begin
            {Grb, Rout, Z_in} = '1;
            alu_instruction_bits = alu_code;
          end
          C_MD: {Gra, Rout, Y_in} = '1;
          C_LD, C_LDI, C_ST: {Grb, BAout, Y_in} = '1;
          C_BR: {Gra, Rout, CON_in} = '1;
          C_JR: {Gra, Rout, PC_in} = '1;
          C_IN: {InPort_out, Gra, Rin} = '1;
          C_OUT: {Gra, Rout, OutPort_in} = '1;
          C_MFHI: {HI_out, Gra, Rin} = '1;
          C_MFLO: {LO_out, Gra, Rin} = '1;
          default: ;
        endcase
      T4:
        case (cls)
          C_REG, C_MD: begin
            {Rout, Z_in} = '1;
            Grc = (cls == C_REG);
            Grb = (cls == C_MD);
            alu_instruction_bits = alu_code;
          end
          C_IMM, C_LD, C_LDI, C_ST: begin
            {C_out, Z_in} = '1;
            alu_instruction_bits = alu_code;
          end
          C_UN: {Zlow_out, Gra, Rin} = '1;
          C_BR: {PC_out, Y_in} = '1;
          default: ;
        endcase
      T5:
        case (cls)
          C_REG, C_IMM, C_LDI: {Zlow_out, Gra, Rin} = '1;
          C_MD: {Zlow_out, LO_in} = '1;
          C_LD, C_ST: {Zlow_out, MAR_in} = '1;
          C_BR: begin
            {C_out, Z_in} = '1;
            alu_instruction_bits = alu_code;
          end
          default: ;
        endcase
      T6:
        case (cls)
          C_MD: {Zhigh_out, HI_in} = '1;
          C_LD: {Read, MDR_in} = '1;
          C_ST: {Gra, Rout, MDR_in} = '1;
          C_BR: {Zlow_out, PC_in} = {2{CON_out}};
          default: ;
        endcase
      T7:
        case (cls)
          C_LD: {MDR_out, Gra, Rin} = '1;
          C_ST: Write = 1'b1;
          default: ;
        endcase
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: random instruction stream checked cycle-by-cycle against a per-opcode
// table of expected control words, including halt, nop-class opcodes and mid-instruction reset.
module tb_control_unit;
  logic clk = 0, clr = 1, CON_out = 0;
  logic [31:0] IR_Data = '0;
  logic PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, CON_in, Rin;
  logic PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out, Rout, BAout;
  logic IncPC, Read, Write, Gra, Grb, Grc, Run;
  logic [4:0] alu_instruction_bits;
  logic [32:0] obs;
  logic [32:0] exp_q[$];
  int tests = 0, fails = 0;
  localparam logic [32:0] PCI = 33'd1 << 0, IRI = 33'd1 << 1, YI = 33'd1 << 2, ZI = 33'd1 << 3;
  localparam logic [32:0] HII = 33'd1 << 4, LOI = 33'd1 << 5, MARI = 33'd1 << 6, MDRI = 33'd1 << 7;
  localparam logic [32:0] OPI = 33'd1 << 8, CONI = 33'd1 << 9, RI = 33'd1 << 10, PCO = 33'd1 << 11;
  localparam logic [32:0] ZHI = 33'd1 << 12, ZLO = 33'd1 << 13, HIO = 33'd1 << 14, LOO = 33'd1 << 15;
  localparam logic [32:0] MDRO = 33'd1 << 16, INO = 33'd1 << 17, CO = 33'd1 << 18, RO = 33'd1 << 19;
  localparam logic [32:0] BAO = 33'd1 << 20, INC = 33'd1 << 21, RD = 33'd1 << 22, WR = 33'd1 << 23;
  localparam logic [32:0] GRA = 33'd1 << 24, GRB = 33'd1 << 25, GRC = 33'd1 << 26, RUN = 33'd1 << 32;

  control_unit dut (
    .clk(clk), .clr(clr), .IR_Data(IR_Data), .CON_out(CON_out),
    .PC_in(PC_in), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in), .HI_in(HI_in), .LO_in(LO_in),
    .MAR_in(MAR_in), .MDR_in(MDR_in), .OutPort_in(OutPort_in), .CON_in(CON_in), .Rin(Rin),
    .PC_out(PC_out), .Zhigh_out(Zhigh_out), .Zlow_out(Zlow_out), .HI_out(HI_out),
    .LO_out(LO_out), .MDR_out(MDR_out), .InPort_out(InPort_out), .C_out(C_out), .Rout(Rout),
    .BAout(BAout), .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .alu_instruction_bits(alu_instruction_bits), .Run(Run)
  );

  assign obs = {Run, alu_instruction_bits, Grc, Grb, Gra, Write, Read, IncPC, BAout, Rout, C_out,
                InPort_out, MDR_out, LO_out, HI_out, Zlow_out, Zhigh_out, PC_out, Rin, CON_in,
                OutPort_in, MDR_in, MAR_in, LO_in, HI_in, Z_in, Y_in, IR_in, PC_in};

  always #5 clk = ~clk;

  function automatic logic [32:0] A(input logic [4:0] c);
    return {1'b0, c, 27'd0};
  endfunction

  // Expected control words, one per cycle from T0, for one instruction.
  task automatic build(input logic [4:0] op, input logic con);
    logic [32:0] x[$];
    x = {PCO | MARI | INC | ZI, ZLO | PCI | RD | MDRI, MDRO | IRI};
    if (op >= 3 && op <= 11) x = {x, GRB | RO | YI, GRC | RO | A(op) | ZI, ZLO | GRA | RI};
    else if (op >= 12 && op <= 14)
      x = {x, GRB | RO | YI, CO | A(op == 13 ? 5'd5 : op == 14 ? 5'd6 : 5'd3) | ZI, ZLO | GRA | RI};
`ifdef MUL_DIV_EN
    else if (op == 15 || op == 16)
      x = {x, GRA | RO | YI, GRB | RO | A(op) | ZI, ZLO | LOI, ZHI | HII};
`endif
    else if (op == 17 || op == 18) x = {x, GRB | RO | A(op) | ZI, ZLO | GRA | RI};
    else if (op == 0) x = {x, GRB | BAO | YI, CO | A(3) | ZI, ZLO | MARI, RD | MDRI, MDRO | GRA | RI};
    else if (op == 1) x = {x, GRB | BAO | YI, CO | A(3) | ZI, ZLO | GRA | RI};
    else if (op == 2) x = {x, GRB | BAO | YI, CO | A(3) | ZI, ZLO | MARI, GRA | RO | MDRI, WR};
    else if (op == 19) x = {x, GRA | RO | CONI, PCO | YI, CO | A(3) | ZI, con ? ZLO | PCI : 33'd0};
    else if (op == 20) x = {x, GRA | RO | PCI};
    else if (op == 22) x = {x, INO | GRA | RI};
    else if (op == 23) x = {x, GRA | RO | OPI};
    else if (op == 24) x = {x, HIO | GRA | RI};
    else if (op == 25) x = {x, LOO | GRA | RI};
    exp_q = {};
    foreach (x[i]) exp_q.push_back(x[i] | RUN);
    if (op == 27) repeat (20) exp_q.push_back(33'd0);
  endtask

  task automatic chk(input string tag, input logic [32:0] e);
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic reset_now();
    clr = 1;
    #1 chk("reset_async", RUN);
    @(negedge clk);
    #1 chk("reset_hold", RUN);
    clr = 0;
  endtask

  task automatic run_instr(input logic [4:0] op, input logic con, input int cut);
    build(op, con);
    foreach (exp_q[k]) begin
      @(negedge clk);
      if (k == 0) IR_Data = {op, 27'($urandom)};
      CON_out = (k == 6) ? con : 1'($urandom);
      #1 chk($sformatf("op%0d_step%0d", op, k), exp_q[k]);
      if (k == cut) begin
        reset_now();
        return;
      end
    end
    if (op == 27) reset_now();
  endtask

  initial begin
    reset_now();
    for (int i = 0; i <= 32; i++)
      run_instr(i == 32 ? 5'd19 : 5'(i), i != 32, -1);
    run_instr(5'd0, 1'b0, 5);
    run_instr(5'd0, 1'b0, -1);
    for (int n = 0; n < 200; n++) begin
      logic [4:0] op;
      op = 5'($urandom);
      build(op, 1'b0);
      run_instr(op, 1'($urandom),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, exp_q.size() - 1)) : -1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/control_unit.md
# control_unit

Hardwired Mini SRC control sequencer: the block that drives the datapath's control inputs, replacing hand-stepped bench stimulus. It runs instruction fetch, decodes `IR_Data`, and steps each instruction class through its T-state sequence. It consumes `CON_out` from the CON FF for conditional branches. It sits beside `datapath` at CPU top level, one output per datapath control input.

## Interface
- No parameters.
- `clk`  input  1  system clock; all state changes on rising edge.
- `clr`  input  1  asynchronous, active-high reset.
- `IR_Data`  input  32  instruction register; opcode = [31:27].
- `CON_out`  input  1  branch condition result from CON FF.
- Register-load strobes, each an output of width 1: `PC_in`, `IR_in`, `Y_in`, `Z_in`, `HI_in`, `LO_in`, `MAR_in`, `MDR_in`, `OutPort_in`, `CON_in`, `Rin`.
- Bus-drive strobes, each an output of width 1: `PC_out`, `Zhigh_out`, `Zlow_out`, `HI_out`, `LO_out`, `MDR_out`, `InPort_out`, `C_out`, `Rout`, `BAout`.
- Miscellaneous single-bit outputs: `IncPC`, `Read`, `Write`, `Gra`, `Grb`, `Grc` (each output, width 1).
- `alu_instruction_bits`  output  5  ALU operation select.
- `Run`  output  1  high unless halted.

## Operation
- **State register:** IDLE, T0–T7, HALT.
- **Output decode:** outputs are combinational from state, `IR_Data[31:27]`, and `CON_out`. Any signal not listed for a state is 0.
- **Opcodes:**
  - ld 00000, ldi 00001, st 00010
  - add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011
  - addi 01100, andi 01101, ori 01110
  - div 01111, mul 10000
  - neg 10001, not 10010
  - br 10011, jr 10100
  - in 10110, out 10111
  - mfhi 11000, mflo 11001
  - nop 11010, halt 11011
  - All other opcodes execute as nop.
- **Fetch:**
  - T0: `PC_out`, `MAR_in`, `IncPC`, `Z_in`
  - T1: `Zlow_out`, `PC_in`, `Read`, `MDR_in`
  - T2: `MDR_out`, `IR_in`
- **ALU codes:** reg ops drive `alu_instruction_bits` = opcode. addi/ld/ldi/st/br drive 00011; andi drives 00101; ori drives 00110.
- **Reg ALU (add..shl):**
  - T3: `Grb`, `Rout`, `Y_in`
  - T4: `Grc`, `Rout`, alu, `Z_in`
  - T5: `Zlow_out`, `Gra`, `Rin`
- **Immediate (addi/andi/ori):**
  - T3: `Grb`, `Rout`, `Y_in`
  - T4: `C_out`, alu, `Z_in`
  - T5: `Zlow_out`, `Gra`, `Rin`
- **neg/not:**
  - T3: `Grb`, `Rout`, alu, `Z_in`
  - T4: `Zlow_out`, `Gra`, `Rin`
- **mul/div:**
  - T3: `Gra`, `Rout`, `Y_in`
  - T4: `Grb`, `Rout`, alu, `Z_in`
  - T5: `Zlow_out`, `LO_in`
  - T6: `Zhigh_out`, `HI_in`
- **ld/ldi/st address phase:**
  - T3: `Grb`, `BAout`, `Y_in`
  - T4: `C_out`, add, `Z_in`
- **ldi:** T5: `Zlow_out`, `Gra`, `Rin`.
- **ld:**
  - T5: `Zlow_out`, `MAR_in`
  - T6: `Read`, `MDR_in`
  - T7: `MDR_out`, `Gra`, `Rin`
- **st:**
  - T5: `Zlow_out`, `MAR_in`
  - T6: `Gra`, `Rout`, `MDR_in`
  - T7: `Write`
- **br:**
  - T3: `Gra`, `Rout`, `CON_in`
  - T4: `PC_out`, `Y_in`
  - T5: `C_out`, add, `Z_in`
  - T6: `Zlow_out` and `PC_in` only if `CON_out` = 1; otherwise T6 is an all-zero cycle.
- **Single-step ops (T3 only):**
  - jr: `Gra`, `Rout`, `PC_in`
  - in: `InPort_out`, `Gra`, `Rin`
  - out: `Gra`, `Rout`, `OutPort_in`
  - mfhi: `HI_out`, `Gra`, `Rin`
  - mflo: `LO_out`, `Gra`, `Rin`
- **Sequence end:** after the last listed state, the next state is T0.
- **nop:** returns to T0 after T2.
- **halt:** T2 → HALT. HALT drives all outputs 0 and `Run` = 0, and holds until `clr`.

## Timing
- **Reset:** `clr` forces IDLE immediately, independent of `clk`. IDLE drives all outputs 0 and `Run` = 1.
- **IDLE:** the first rising edge with `clr` low moves IDLE → T0.
- **State duration:** one state per `clk` cycle; each strobe is high for exactly that full cycle.
- **Decode timing:** `IR_in` loads at the end of T2, so decode from T3 onward sees the new instruction.
- **Memory:** `Read` + `MDR_in` in the same cycle capture data at the end of that cycle (single-cycle RAM).
- **Cycles per instruction, counted from T0:**
  - nop: 3
  - jr/in/out/mfhi/mflo: 4
  - neg/not: 5
  - reg ALU, immediate, ldi: 6
  - mul/div, br: 7 (br costs 7 whether taken or not)
  - ld/st: 8
- **Reset mid-instruction:** `clr` abandons the instruction. No strobe may assert after `clr` rises. `PC` retains its datapath value.
- **Branch condition:** `CON_out` is sampled combinationally during T6 only.

## Configuration
- `MUL_DIV_EN` defined: the mul/div sequence above is compiled in.
- `MUL_DIV_EN` undefined: opcodes 01111 and 10000 decode as nop (3 cycles). `HI_in` and `LO_in` are never asserted.

## Test plan
- **Reg ALU:** R2=5, R3=7, `add R1,R2,R3` at 0; pulse `clr` → R1=12 and PC=1, exactly 6 cycles after T0.
- **ld:** R1=0x10, mem[0x75]=0xABCD, `ld R2,0x65(R1)` → R2=0xABCD after 8 cycles; `Read` high in T1 and T6 only.
- **br taken:** `brzr R6,25` with R6=0 → PC=26.
- **br not taken:** same instruction with R6=5 → PC=1, and `PC_in` stays low in T6.
- **halt:** `halt` → `Run`=0 from the cycle after T2 and all strobes stay 0 for 20 cycles. `clr` then gives IDLE → T0 fetching from the current PC.
- **Reset mid-ld:** assert `clr` during T5 of `ld` → all outputs 0 within the same cycle; no `Read`/`MDR_in` pulse and R2 unchanged.
- **mul:** R4=0x10000, R5=0x10000, `mul R4,R5` → HI=1, LO=0 with `MUL_DIV_EN`. Without it, HI/LO are unchanged and the next fetch occurs 3 cycles after T0.
